// File: rtl/mapper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mapper_pkg
//  Purpose  : Shared port-offset helpers, status-byte layout and a status
//             packing function for the mapper register file.
//  Revision : 1.0 - initial release
// ============================================================================
package mapper_pkg;

  // Status byte layout: {overflow, full, empty, count[4:0]}
  localparam int ST_OVF     = 7;
  localparam int ST_FULL    = 6;
  localparam int ST_EMPTY   = 5;
  localparam int ST_CNT_LSB = 0;
  localparam int ST_CNT_W   = 5;

  // The ISR data port sits directly after the last control register and
  // the status port directly after that, so both offsets follow NUM_REGS.
  function automatic int isr_data_offset(input int num_regs);
    return num_regs;
  endfunction

  function automatic int status_offset(input int num_regs);
    return num_regs + 1;
  endfunction

  function automatic logic [7:0] pack_status(input logic ovf,
                                             input logic full,
                                             input logic empty,
                                             input logic [ST_CNT_W-1:0] cnt);
    logic [7:0] s;
    s                          = 8'h00;
    s[ST_OVF]                  = ovf;
    s[ST_FULL]                 = full;
    s[ST_EMPTY]                = empty;
    s[ST_CNT_LSB +: ST_CNT_W]  = cnt;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/isr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : isr_fifo
//  Purpose  : Byte FIFO holding recorded opcode history. Supports push and
//             pop in the same clock even when full, and keeps a sticky
//             overflow flag that is set when a push has to be dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module isr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       clr_ovf,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_do_pop;
  logic w_do_push;
  logic w_drop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  // A pop frees a slot in the same clock, so a full FIFO still accepts a push
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign w_drop    = push & full & ~w_do_pop;

  // Storage needs no reset: entries are only visible through the pointers
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer, occupancy and overflow bookkeeping; a dropped push beats a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign head     = empty ? 8'h00 : r_mem[r_rd_ptr];
  assign count    = 5'(r_count);
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: rtl/mapper_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : mapper_register_file
//  Purpose  : Clocked MegaMapper control/ISR register block. Synchronises
//             the Z80 bus strobes, decodes NUM_REGS control registers plus an
//             ISR data port and a status port, and records M1 opcode bytes
//             into a history FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module mapper_register_file
  import mapper_pkg::*;
#(
  parameter int                NUM_REGS    = 4,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 8'h30,
  parameter int                ISR_DEPTH   = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [7:0]        RESET_VALUE = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  input  logic                  wr_n,
  input  logic                  rd_n,
  input  logic                  iorq_n,
  input  logic                  m1_n,
  input  logic                  record_isr,
  output logic [NUM_REGS*8-1:0] ctrl_q,
  output logic                  isr_pending
);

  localparam logic [ADDR_W-1:0] C_OFS_ISR    = ADDR_W'(isr_data_offset(NUM_REGS));
  localparam logic [ADDR_W-1:0] C_OFS_STATUS = ADDR_W'(status_offset(NUM_REGS));

  // ---------------------------------------------------------------- strobes
  logic [SYNC_STAGES-1:0] r_wr_sync, r_rd_sync, r_iorq_sync, r_m1_sync;
  logic                   r_wr_prev, r_rd_prev, r_m1_prev;
  logic                   w_wr_s, w_rd_s, w_iorq_s, w_m1_s;
  logic                   w_wr_rise, w_rd_rise, w_m1_rise;

  // Synchroniser chains and edge-detect flops, all idling high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_sync   <= '1;
      r_rd_sync   <= '1;
      r_iorq_sync <= '1;
      r_m1_sync   <= '1;
      r_wr_prev   <= 1'b1;
      r_rd_prev   <= 1'b1;
      r_m1_prev   <= 1'b1;
    end else begin
      r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0], wr_n};
      r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], rd_n};
      r_iorq_sync <= {r_iorq_sync[SYNC_STAGES-2:0], iorq_n};
      r_m1_sync   <= {r_m1_sync[SYNC_STAGES-2:0], m1_n};
      r_wr_prev   <= w_wr_s;
      r_rd_prev   <= w_rd_s;
      r_m1_prev   <= w_m1_s;
    end
  end

  assign w_wr_s    = r_wr_sync[SYNC_STAGES-1];
  assign w_rd_s    = r_rd_sync[SYNC_STAGES-1];
  assign w_iorq_s  = r_iorq_sync[SYNC_STAGES-1];
  assign w_m1_s    = r_m1_sync[SYNC_STAGES-1];
  assign w_wr_rise = w_wr_s & ~r_wr_prev;
  assign w_rd_rise = w_rd_s & ~r_rd_prev;
  assign w_m1_rise = w_m1_s & ~r_m1_prev;

  // ---------------------------------------------------------------- capture
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_wr_armed;
  logic [7:0]        r_m1_data;
  logic              r_m1_rec;
  logic              r_wr_ev, r_rd_ev, r_m1_ev;

  // Holding registers track the bus while strobes are low; the last sample
  // before the trailing edge is what gets committed. Trailing edges are
  // registered so the action lands one clock after the edge is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
      r_wr_armed <= 1'b0;
      r_m1_data  <= 8'h00;
      r_m1_rec   <= 1'b0;
      r_wr_ev    <= 1'b0;
      r_rd_ev    <= 1'b0;
      r_m1_ev    <= 1'b0;
    end else begin
      if (!w_wr_s && !w_iorq_s) begin
        r_wr_addr  <= addr;
        r_wr_data  <= data_in;
        r_wr_armed <= 1'b1;
      end else if (w_wr_rise) begin
        r_wr_armed <= 1'b0;
      end
      if (!w_m1_s) begin
        r_m1_data <= data_in;
        r_m1_rec  <= record_isr;
      end
      r_wr_ev <= w_wr_rise & r_wr_armed;
      r_rd_ev <= w_rd_rise;
      r_m1_ev <= w_m1_rise & r_m1_rec;
    end
  end

  // ---------------------------------------------------------------- writes
  logic [ADDR_W-1:0]     w_wr_ofs;
  logic                  w_wr_hit;
  logic                  w_clr_ovf;
  logic [NUM_REGS*8-1:0] r_ctrl;

  assign w_wr_ofs  = r_wr_addr - ADDR_BASE;
  assign w_wr_hit  = r_wr_ev && (r_wr_addr >= ADDR_BASE);
  assign w_clr_ovf = w_wr_hit && (w_wr_ofs == C_OFS_STATUS) && r_wr_data[ST_OVF];

  // Control register commit on a decoded IO write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= {NUM_REGS{RESET_VALUE}};
    end else if (w_wr_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_ofs == ADDR_W'(i)) begin
          r_ctrl[8*i +: 8] <= r_wr_data;
        end
      end
    end
  end

  assign ctrl_q = r_ctrl;

  // ---------------------------------------------------------------- FIFO
  logic [7:0] w_head;
  logic [4:0] w_count;
  logic       w_full, w_empty, w_ovf;
  logic       r_rd_isr;
  logic       w_pop;

  assign w_pop = r_rd_ev & r_rd_isr;

  isr_fifo #(
    .DEPTH (ISR_DEPTH)
  ) u_isr_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (r_m1_ev),
    .pop      (w_pop),
    .clr_ovf  (w_clr_ovf),
    .din      (r_m1_data),
    .head     (w_head),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_empty),
    .overflow (w_ovf)
  );

  // ---------------------------------------------------------------- reads
  logic [ADDR_W-1:0] w_rd_ofs;
  logic              w_rd_active;
  logic [7:0]        w_rd_data;
  logic [7:0]        r_dout;
  logic              r_oe;
  logic              r_pending;

  assign w_rd_ofs    = addr - ADDR_BASE;
  assign w_rd_active = !w_rd_s && !w_iorq_s &&
                       (addr >= ADDR_BASE) && (w_rd_ofs <= C_OFS_STATUS);

  // Readback multiplexer across registers, ISR head and status
  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_ofs == ADDR_W'(i)) begin
        w_rd_data = r_ctrl[8*i +: 8];
      end
    end
    if (w_rd_ofs == C_OFS_ISR) begin
      w_rd_data = w_head;
    end else if (w_rd_ofs == C_OFS_STATUS) begin
      w_rd_data = pack_status(w_ovf, w_full, w_empty, w_count);
    end
  end

  // Registered bus drive; an ISR-port read arms a pop for the RD trailing edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_oe      <= 1'b0;
      r_dout    <= 8'h00;
      r_rd_isr  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_oe <= w_rd_active;
      if (w_rd_active) begin
        r_dout <= w_rd_data;
      end
      if (r_rd_ev) begin
        r_rd_isr <= 1'b0;
      end else if (w_rd_active && (w_rd_ofs == C_OFS_ISR)) begin
        r_rd_isr <= 1'b1;
      end
      r_pending <= (w_count != 5'd0);
    end
  end

  assign data_out    = r_dout;
  assign data_oe     = r_oe;
  assign isr_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_mapper_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mapper_register_file
//  Purpose  : Self-checking bench for mapper_register_file: directed bus
//             cycles followed by random ones, compared against an
//             array/queue model of the register file and ISR history.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mapper_register_file;

  localparam int         SYNC  = 2;
  localparam int         DEPTH = 4;
  localparam logic [7:0] BASE  = 8'h30;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        wr_n, rd_n, iorq_n, m1_n;
  logic        record_isr;
  logic [31:0] ctrl_q;
  logic        isr_pending;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] m_ctrl [4];
  logic [7:0] m_q [$];
  bit         m_ovf;

  // Values seen by the last bus cycle while strobes were low
  logic       s_oe;
  logic [7:0] s_dout;

  mapper_register_file #(
    .NUM_REGS    (4),
    .ADDR_W      (8),
    .ADDR_BASE   (BASE),
    .ISR_DEPTH   (DEPTH),
    .SYNC_STAGES (SYNC),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .wr_n        (wr_n),
    .rd_n        (rd_n),
    .iorq_n      (iorq_n),
    .m1_n        (m1_n),
    .record_isr  (record_isr),
    .ctrl_q      (ctrl_q),
    .isr_pending (isr_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ model
  function automatic logic [31:0] m_ctrl_packed();
    return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
  endfunction

  function automatic logic [7:0] m_status();
    int n = m_q.size();
    return {m_ovf, (n == DEPTH), (n == 0), 5'(n)};
  endfunction

  function automatic bit m_in_window(input logic [7:0] a);
    return (a >= BASE) && (a <= BASE + 8'd5);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int idx = int'(a) - int'(BASE);
    if (idx < 4)  return m_ctrl[idx];
    if (idx == 4) return (m_q.size() == 0) ? 8'h00 : m_q[0];
    return m_status();
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_ctrl[i] = 8'h00;
    m_q.delete();
    m_ovf = 1'b0;
  endfunction

  function automatic void m_write(input logic [7:0] a, input logic [7:0] d);
    int idx = int'(a) - int'(BASE);
    if (a >= BASE && idx < 4) m_ctrl[idx] = d;
    else if (a >= BASE && idx == 5 && d[7]) m_ovf = 1'b0;
  endfunction

  function automatic void m_pop_if(input logic [7:0] a);
    if (a == BASE + 8'd4 && m_q.size() != 0) void'(m_q.pop_front());
  endfunction

  function automatic void m_push(input logic [7:0] d, input bit rec);
    if (!rec) return;
    if (m_q.size() == DEPTH) m_ovf = 1'b1;
    else m_q.push_back(d);
  endfunction

  // ------------------------------------------------------------ bus driver
  // One bus cycle; any combination of WR, RD and M1 strobes may overlap and
  // all trailing edges happen together.
  task automatic bus(input bit wr, input bit rd, input bit m1,
                     input logic [7:0] ta, input logic [7:0] td, input bit rec);
    @(negedge clk);
    addr       = ta;
    data_in    = td;
    record_isr = rec;
    if (wr || rd) iorq_n = 1'b0;
    if (wr) wr_n = 1'b0;
    if (rd) rd_n = 1'b0;
    if (m1) m1_n = 1'b0;
    repeat (4) @(negedge clk);
    s_oe   = data_oe;
    s_dout = data_out;
    wr_n   = 1'b1;
    rd_n   = 1'b1;
    iorq_n = 1'b1;
    m1_n   = 1'b1;
    repeat (6) @(negedge clk);
    record_isr = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    bus(1'b1, 1'b0, 1'b0, a, d, 1'b0);
    m_write(a, d);
    check("ctrl_after_write", ctrl_q, m_ctrl_packed());
  endtask

  task automatic do_push(input logic [7:0] d, input bit rec);
    bus(1'b0, 1'b0, 1'b1, 8'h00, d, rec);
    m_push(d, rec);
    check("pending_after_push", {31'd0, isr_pending}, {31'd0, m_q.size() != 0});
  endtask

  task automatic do_read(input string tag, input logic [7:0] a);
    logic [7:0] exp = m_read(a);
    bit         win = m_in_window(a);
    bus(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b0);
    check({tag, "_oe"}, {31'd0, s_oe}, {31'd0, win});
    if (win) check({tag, "_data"}, {24'd0, s_dout}, {24'd0, exp});
    m_pop_if(a);
    check({tag, "_pending"}, {31'd0, isr_pending}, {31'd0, m_q.size() != 0});
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    logic [7:0] exp_head;
    void'($urandom(32'h1BAD_5EED));
    reset = 1'b1; addr = 8'h00; data_in = 8'h00;
    wr_n = 1'b1; rd_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; record_isr = 1'b0;
    m_reset();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_ctrl", ctrl_q, 32'h0);
    check("reset_oe", {31'd0, data_oe}, 32'd0);
    check("reset_dout", {24'd0, data_out}, 32'd0);
    check("reset_pending", {31'd0, isr_pending}, 32'd0);

    // Write latency: commit exactly SYNC+2 clocks after wr_n rises
    addr = 8'h31; data_in = 8'hA5; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1; iorq_n = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1 check("wr_latency_early", ctrl_q, 32'h0);
    @(posedge clk);
    #1 check("wr_latency_commit", ctrl_q, 32'h0000_A500);
    m_write(8'h31, 8'hA5);
    repeat (4) @(negedge clk);

    do_read("rd_reg1", 8'h31);
    do_read("rd_outside", 8'h40);

    // Opcode history
    do_push(8'hFB, 1'b1);
    do_push(8'hED, 1'b1);
    do_push(8'h4D, 1'b1);
    do_read("status_3", 8'h35);
    do_read("pop_1", 8'h34);
    do_read("pop_2", 8'h34);
    do_read("pop_3", 8'h34);
    do_read("status_empty", 8'h35);
    do_push(8'h99, 1'b0);
    do_read("pop_empty", 8'h34);

    // Overflow and its clear
    for (int i = 0; i < 5; i++) do_push(8'h11 * (i + 1), 1'b1);
    do_read("status_ovf", 8'h35);
    do_write(8'h35, 8'h80);
    do_read("status_cleared", 8'h35);
    bus(1'b1, 1'b0, 1'b1, 8'h35, 8'h80, 1'b1);
    m_write(8'h35, 8'h80);
    m_push(8'h80, 1'b1);
    do_read("status_set_wins", 8'h35);
    do_write(8'h35, 8'h80);

    // Pop and push in the same clock while full
    exp_head = m_read(8'h34);
    bus(1'b0, 1'b1, 1'b1, 8'h34, 8'h5A, 1'b1);
    check("pushpop_head", {24'd0, s_dout}, {24'd0, exp_head});
    m_pop_if(8'h34);
    m_push(8'h5A, 1'b1);
    do_read("pushpop_status", 8'h35);
    do_read("pushpop_next", 8'h34);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      int         op = $urandom_range(0, 3);
      logic [7:0] a  = 8'($urandom_range(32'h2E, 32'h37));
      logic [7:0] d  = 8'($urandom);
      case (op)
        0:       do_write(a, d);
        1:       do_push(d, $urandom_range(0, 3) != 0);
        default: do_read("rand_rd", a);
      endcase
    end

    // Reset in the middle of a write, with FIFO holding data
    do_push(8'h3C, 1'b1);
    @(negedge clk);
    addr = 8'h30; data_in = 8'h77; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    wr_n = 1'b1; iorq_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();
    check("midreset_ctrl", ctrl_q, 32'h0);
    check("midreset_oe", {31'd0, data_oe}, 32'd0);
    check("midreset_pending", {31'd0, isr_pending}, 32'd0);
    repeat (8) @(negedge clk);
    check("midreset_no_commit", ctrl_q, 32'h0);
    do_read("midreset_status", 8'h35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
